// File: rtl/xorexec_pg_top.sv
// ---------------------------------------------------------------------------
// xorexec_pg_top
//
// Purpose:
//   Always-on input FIFO -> power-gated xor execution stage -> always-on
//   output FIFO. An idle-driven controller isolates and powers down the
//   execution stage when no work is pending. When a word arrives it wakes
//   the stage, holding it in reset for a fixed settle time first.
//
// Parameters:
//   DWIDTH        data / key width
//   IDEPTH        input FIFO entries  (power of 2, >= 2)
//   ODEPTH        output FIFO entries (power of 2, >= 2)
//   IDLE_CYCLES   consecutive idle cycles in ON before power-down (>= 1)
//   PWRUP_CYCLES  cycles the stage is held in reset in WAKE (>= 1)
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   ififo_push        write idata into the input FIFO (ignored when full)
//   ififo_not_full    input FIFO can accept a word
//   idata             input word
//   key               xor key, sampled when the stage takes a word
//   pg_en             1 = power gating allowed
//   ofifo_pop         consume odata (ignored when empty)
//   ofifo_rdy         output FIFO non-empty, odata valid
//   odata             output FIFO head (show-ahead), 0 when empty
//   pwr_down          execution stage power switch off
//   iso_enable        execution stage outputs clamped to 0
//   exec_busy         execution stage register holds a word
//
// Optional build macro XOREXEC_PG_STATS_EN adds:
//   stat_words[31:0]  saturating count of words entering the output FIFO
//   stat_pdowns[15:0] saturating count of ISO->OFF transitions
// ---------------------------------------------------------------------------
module xorexec_pg_top #(
    parameter int DWIDTH       = 8,
    parameter int IDEPTH       = 8,
    parameter int ODEPTH       = 8,
    parameter int IDLE_CYCLES  = 16,
    parameter int PWRUP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ififo_push,
    output logic              ififo_not_full,
    input  logic [DWIDTH-1:0] idata,
    input  logic [DWIDTH-1:0] key,
    input  logic              pg_en,
    input  logic              ofifo_pop,
    output logic              ofifo_rdy,
    output logic [DWIDTH-1:0] odata,
    output logic              pwr_down,
    output logic              iso_enable,
    output logic              exec_busy
`ifdef XOREXEC_PG_STATS_EN
    ,
    output logic [31:0]       stat_words,
    output logic [15:0]       stat_pdowns
`endif
);

    localparam int IPW = $clog2(IDEPTH);
    localparam int ICW = IPW + 1;
    localparam int OPW = $clog2(ODEPTH);
    localparam int OCW = OPW + 1;
    localparam int IDW = $clog2(IDLE_CYCLES + 1);
    localparam int WUW = $clog2(PWRUP_CYCLES + 1);

    localparam logic [ICW-1:0] IFULL    = ICW'(IDEPTH);
    localparam logic [OCW-1:0] OFULL    = OCW'(ODEPTH);
    localparam logic [IDW-1:0] IDLE_MAX = IDW'(IDLE_CYCLES);
    localparam logic [WUW-1:0] WU_LAST  = WUW'(PWRUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_ISO  = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } pstate_t;

    pstate_t state, state_nxt;

    // Input FIFO storage and control
    logic [DWIDTH-1:0] imem [IDEPTH];
    logic [IPW-1:0]    iwr, ird;
    logic [ICW-1:0]    icnt;
    logic              i_empty, ipush, ipop;

    // Execution stage
    logic [DWIDTH-1:0] stg_data_p1;
    logic              stg_vld_p1;
    logic [DWIDTH-1:0] exec_out;
    logic              fire, stg_push;

    // Output FIFO storage and control
    logic [DWIDTH-1:0] omem [ODEPTH];
    logic [OPW-1:0]    owr, ord;
    logic [OCW-1:0]    ocnt;
    logic              o_empty, o_not_full, opop;

    // Power controller counters
    logic [IDW-1:0]    idle_cnt;
    logic [WUW-1:0]    wu_cnt;
    logic              idle_now;

    // ---------------- input FIFO (always-on) ----------------
    assign i_empty        = (icnt == '0);
    assign ififo_not_full = (icnt != IFULL);
    assign ipush          = ififo_push && ififo_not_full;
    assign ipop           = fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            iwr  <= '0;
            ird  <= '0;
            icnt <= '0;
        end else begin
            if (ipush) iwr <= iwr + IPW'(1);
            if (ipop)  ird <= ird + IPW'(1);
            case ({ipush, ipop})
                2'b10:   icnt <= icnt + ICW'(1);
                2'b01:   icnt <= icnt - ICW'(1);
                default: icnt <= icnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ipush) imem[iwr] <= idata;
    end

    // ---------------- execution stage p1 (gated domain) ----------------
    // The stage only takes new work in ON; in the other states it is known
    // empty, and the isolation clamp keeps anything it drives at zero.
    assign stg_push = stg_vld_p1 && o_not_full && !iso_enable;
    assign fire     = (state == ST_ON) && !i_empty && (!stg_vld_p1 || stg_push);
    assign exec_out = iso_enable ? '0 : stg_data_p1;

    always_ff @(posedge clk) begin
        if (rst || state == ST_WAKE) begin
            stg_vld_p1 <= 1'b0;
        end else if (fire) begin
            stg_vld_p1 <= 1'b1;
        end else if (stg_push) begin
            stg_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) stg_data_p1 <= imem[ird] ^ key;
    end

    assign exec_busy = stg_vld_p1;

    // ---------------- output FIFO (always-on) ----------------
    assign o_empty    = (ocnt == '0);
    assign o_not_full = (ocnt != OFULL);
    assign opop       = ofifo_pop && !o_empty;
    assign ofifo_rdy  = !o_empty;
    assign odata      = o_empty ? '0 : omem[ord];

    always_ff @(posedge clk) begin
        if (rst) begin
            owr  <= '0;
            ord  <= '0;
            ocnt <= '0;
        end else begin
            if (stg_push) owr <= owr + OPW'(1);
            if (opop)     ord <= ord + OPW'(1);
            case ({stg_push, opop})
                2'b10:   ocnt <= ocnt + OCW'(1);
                2'b01:   ocnt <= ocnt - OCW'(1);
                default: ocnt <= ocnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (stg_push) omem[owr] <= exec_out;
    end

    // ---------------- power controller ----------------
    assign idle_now = !stg_vld_p1 && i_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ON;
        else     state <= state_nxt;
    end

    // ON->ISO also requires idle this cycle, so a word that landed in the
    // input FIFO on the previous edge is executed rather than stranded in
    // the stage while it is powered down.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ON:   if (idle_now && pg_en && idle_cnt == IDLE_MAX) state_nxt = ST_ISO;
            ST_ISO:  state_nxt = ST_OFF;
            ST_OFF:  if (!i_empty || !pg_en) state_nxt = ST_WAKE;
            ST_WAKE: if (wu_cnt == WU_LAST) state_nxt = ST_ON;
            default: state_nxt = ST_ON;
        endcase
    end

    always_comb begin
        pwr_down   = (state == ST_OFF);
        iso_enable = (state != ST_ON);
    end

    // Idle counter saturates at IDLE_MAX, so with pg_en low it simply waits
    // there; outside ON it is held clear, which re-arms it for the next ON.
    always_ff @(posedge clk) begin
        if (rst || state != ST_ON || !idle_now) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != ST_WAKE) wu_cnt <= '0;
        else                         wu_cnt <= wu_cnt + WUW'(1);
    end

`ifdef XOREXEC_PG_STATS_EN
    // ---------------- statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words  <= '0;
            stat_pdowns <= '0;
        end else begin
            if (stg_push && stat_words != '1)        stat_words  <= stat_words + 32'd1;
            if (state == ST_ISO && stat_pdowns != '1) stat_pdowns <= stat_pdowns + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xorexec_pg_top.sv
module tb_xorexec_pg_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       ififo_push;
    logic       ififo_not_full;
    logic [7:0] idata;
    logic [7:0] key;
    logic       pg_en;
    logic       ofifo_pop;
    logic       ofifo_rdy;
    logic [7:0] odata;
    logic       pwr_down;
    logic       iso_enable;
    logic       exec_busy;
`ifdef XOREXEC_PG_STATS_EN
    logic [31:0] stat_words;
    logic [15:0] stat_pdowns;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    xorexec_pg_top #(
        .DWIDTH(8), .IDEPTH(8), .ODEPTH(8), .IDLE_CYCLES(16), .PWRUP_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ififo_push(ififo_push),
        .ififo_not_full(ififo_not_full),
        .idata(idata),
        .key(key),
        .pg_en(pg_en),
        .ofifo_pop(ofifo_pop),
        .ofifo_rdy(ofifo_rdy),
        .odata(odata),
        .pwr_down(pwr_down),
        .iso_enable(iso_enable),
        .exec_busy(exec_busy)
`ifdef XOREXEC_PG_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_pdowns(stat_pdowns)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected word queued when the push is accepted, checked
    // when the consumer pops it.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (ofifo_pop && ofifo_rdy) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    chk("odata", 32'(odata), 32'(sb_q[0]));
                    void'(sb_q.pop_front());
                end
            end
            if (ififo_push && ififo_not_full) sb_q.push_back(idata ^ key);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic pg);
        rst        = 1'b1;
        ififo_push = 1'b0;
        ofifo_pop  = 1'b0;
        idata      = 8'h00;
        pg_en      = pg;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        ififo_push = 1'b1;
        idata      = d;
        tick();
        ififo_push = 1'b0;
    endtask

    task automatic drain();
        ofifo_pop = 1'b1;
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick();
        ofifo_pop = 1'b0;
        chk("drain_left", 32'(sb_q.size()), 32'd0);
    endtask

    // Counts WAKE cycles (iso high, power on) after leaving OFF.
    task automatic count_wake(input string tag);
        int   n;
        logic busy_seen;
        n = 0;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (iso_enable && !pwr_down) begin
                n++;
                if (exec_busy) busy_seen = 1'b1;
            end else begin
                break;
            end
        end
        chk({tag, "_wake_len"}, 32'(n), 32'd4);
        chk({tag, "_wake_busy"}, 32'(busy_seen), 32'd0);
        chk({tag, "_on_iso"}, 32'(iso_enable), 32'd0);
        chk({tag, "_on_pd"}, 32'(pwr_down), 32'd0);
    endtask

    task automatic wait_off(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (pwr_down) break;
            tick();
        end
        chk({tag, "_off"}, 32'(pwr_down), 32'd1);
    endtask

    task automatic scen1();
        push_word(8'h3C);
        chk("s1_rdy_e1", 32'(ofifo_rdy), 32'd0);
        tick();
        chk("s1_busy_e2", 32'(exec_busy), 32'd1);
        chk("s1_rdy_e2", 32'(ofifo_rdy), 32'd0);
        tick();
        chk("s1_rdy_e3", 32'(ofifo_rdy), 32'd1);
        chk("s1_odata", 32'(odata), 32'h99);
        chk("s1_iso", 32'(iso_enable), 32'd0);
        chk("s1_pd", 32'(pwr_down), 32'd0);
        drain();
    endtask

    task automatic scen3_body();
        pg_en = 1'b1;
        wait_off("s3");
        tick();
        tick();
        chk("s3_off_hold", 32'(pwr_down), 32'd1);
        push_word(8'h01);
        chk("s3_off_push", 32'(pwr_down), 32'd1);
        count_wake("s3");
        drain();
    endtask

    initial begin
        int   n;
        int   viol;
        key = 8'hA5;
        do_reset(1'b0);

        // reset state
        chk("rst_not_full", 32'(ififo_not_full), 32'd1);
        chk("rst_rdy", 32'(ofifo_rdy), 32'd0);
        chk("rst_odata", 32'(odata), 32'd0);
        chk("rst_pd", 32'(pwr_down), 32'd0);
        chk("rst_iso", 32'(iso_enable), 32'd0);
        chk("rst_busy", 32'(exec_busy), 32'd0);

        // single word latency and value
        scen1();

        // backpressure: 18 pushes with no pops
        ofifo_pop = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ififo_push = 1'b1;
            idata      = 8'(8'h10 + i * 3);
            tick();
            if (i == 15) begin
                chk("s2_nf_16", 32'(ififo_not_full), 32'd1);
                chk("s2_busy_16", 32'(exec_busy), 32'd1);
                chk("s2_rdy_16", 32'(ofifo_rdy), 32'd1);
            end
            if (i == 16) chk("s2_nf_17", 32'(ififo_not_full), 32'd0);
        end
        ififo_push = 1'b0;
        chk("s2_queued", 32'(sb_q.size()), 32'd17);
        drain();
        tick();
        chk("s2_rdy_empty", 32'(ofifo_rdy), 32'd0);
        chk("s2_odata_empty", 32'(odata), 32'd0);
        chk("s2_busy_empty", 32'(exec_busy), 32'd0);

        // idle power-down timing from reset
        do_reset(1'b1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (iso_enable) break;
            tick();
            n++;
        end
        chk("s3_iso_lat_ok", 32'(n == 16 || n == 17), 32'd1);
        chk("s3_pd_in_iso", 32'(pwr_down), 32'd0);
        tick();
        chk("s3_pd_after", 32'(pwr_down), 32'd1);
        chk("s3_iso_after", 32'(iso_enable), 32'd1);
        scen3_body();

        // wake by pg_en going low, then stay ON
        wait_off("s4");
        pg_en = 1'b0;
        count_wake("s4");
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (iso_enable || pwr_down) viol++;
        end
        chk("s4_stay_on", 32'(viol), 32'd0);

        // reset mid-operation
        ofifo_pop = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'(8'h50 + i));
        chk("s5_busy_pre", 32'(exec_busy), 32'd1);
        chk("s5_rdy_pre", 32'(ofifo_rdy), 32'd1);
        rst = 1'b1;
        tick();
        chk("s5_rdy", 32'(ofifo_rdy), 32'd0);
        chk("s5_nf", 32'(ififo_not_full), 32'd1);
        chk("s5_busy", 32'(exec_busy), 32'd0);
        chk("s5_odata", 32'(odata), 32'd0);
        chk("s5_iso", 32'(iso_enable), 32'd0);
        chk("s5_pd", 32'(pwr_down), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("s5_rdy_later", 32'(ofifo_rdy), 32'd0);
        chk("s5_busy_later", 32'(exec_busy), 32'd0);

`ifdef XOREXEC_PG_STATS_EN
        do_reset(1'b0);
        chk("st_words_rst", stat_words, 32'd0);
        chk("st_pdowns_rst", 32'(stat_pdowns), 32'd0);
        scen1();
        scen3_body();
        chk("st_words", stat_words, 32'd2);
        chk("st_pdowns", 32'(stat_pdowns), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
